key_debounce_multi: RTL

Parametrised multi-channel key debouncer and press classifier. Each channel synchronises one raw key input, filters bounce with a per-channel stability counter, and reports a debounced level plus single-cycle press, release, long-press and auto-repeat events. It sits between board push-buttons and the control FSMs, replacing single-key, single-event debouncing with a generalised N-key block.

---
 rtl/key_debounce_multi.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   Multi-channel key debouncer and press classifier. Each channel
//   synchronises a raw key, filters bounce with a stability counter and
//   reports a debounced pressed level plus one-cycle press, release,
//   long-press and auto-repeat events.
//
// Ports
//   sysclk         clock, all logic on the rising edge
//   rst_n          synchronous active-low reset
//   key_in         raw asynchronous key levels, one bit per channel
//   key_state      debounced pressed level (1 = pressed for either polarity)
//   press_pulse    one-cycle pulse when a press is accepted
//   release_pulse  one-cycle pulse when a release is accepted
//   long_pulse     one-cycle pulse LONG_CYC cycles after the press pulse
//   repeat_pulse   one-cycle pulse every REPEAT_CYC cycles while long-held
module key_debounce_multi #(
  parameter int NUM_KEYS     = 4,
  parameter bit ACTIVE_LEVEL = 1'b1,
  parameter int DEBOUNCE_CYC = 2_500_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    logic          sync1_q, sync2_q;
    logic          act;
    logic          accept;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          kst_q, kst_d;
    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;

    // Two-flop synchroniser; resets to the idle level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge sysclk) begin
      if (!rst_n) begin
        sync1_q <= ~ACTIVE_LEVEL;
        sync2_q <= ~ACTIVE_LEVEL;
      end else begin
        sync1_q <= key_in[k];
        sync2_q <= sync1_q;
      end
    end

    // Normalised to 1 = pressed so the rest of the channel is polarity-free.
    assign act = ~(sync2_q ^ ACTIVE_LEVEL);

    // Stability filter: any return to the current debounced level restarts
    // the count, so only an uninterrupted run of DEBOUNCE_CYC cycles flips it.
    always_comb begin
      dcnt_d = dcnt_q;
      kst_d  = kst_q;
      accept = 1'b0;
      if (act == kst_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
        kst_d  = act;
        dcnt_d = '0;
        accept = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    // Press classifier. The release branch is tested first in PRESSED and
    // LONG so that a release coinciding with a long/repeat event wins.
    // hcnt parks at its last value once LONG is reached.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      rcnt_d  = rcnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && act) begin
            state_d = PRESSED;
            press_d = 1'b1;
            hcnt_d  = '0;
            rcnt_d  = '0;
          end
        end
        PRESSED: begin
          if (accept && !act) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            hcnt_d  = '0;
            rcnt_d  = '0;
          end else if (hcnt_q == HCNT_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
            rcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        LONG: begin
          if (accept && !act) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            hcnt_d  = '0;
            rcnt_d  = '0;
          end else if (REPEAT_EN) begin
            if (rcnt_q == RCNT_LAST) begin
              rep_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge sysclk) begin
      if (!rst_n) begin
        dcnt_q  <= '0;
        kst_q   <= 1'b0;
        state_q <= IDLE;
        hcnt_q  <= '0;
        rcnt_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        dcnt_q  <= dcnt_d;
        kst_q   <= kst_d;
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        rcnt_q  <= rcnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
      end
    end

    assign key_state[k]     = kst_q;
    assign press_pulse[k]   = press_q;
    assign release_pulse[k] = rel_q;
    assign long_pulse[k]    = long_q;
    assign repeat_pulse[k]  = rep_q;
  end

endmodule
